// File: rtl/leb128_encoder_if.sv
// leb128_encoder_if: operand-in / byte-out handshake bundle for the LEB128 encoder
//   in_value  [WIDTH] integer to encode       in_signed  1 = SLEB128, 0 = ULEB128
//   in_valid          operand valid            in_ready   encoder idle, takes operand
//   out_byte  [8]     {continuation, payload}  out_valid  out_byte valid
//   out_ready         downstream takes byte    out_last   final byte of sequence
//   out_index [4]     0-based byte index
//   master = producer of operands / consumer of bytes, slave = the encoder
interface leb128_encoder_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] in_value;
    logic             in_signed;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_byte;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [3:0]       out_index;

    modport master (
        output in_value, in_signed, in_valid, out_ready,
        input  in_ready, out_byte, out_valid, out_last, out_index
    );

    modport slave (
        input  in_value, in_signed, in_valid, out_ready,
        output in_ready, out_byte, out_valid, out_last, out_index
    );
endinterface

// File: rtl/leb128_encoder.sv
// leb128_encoder: streams one WIDTH-bit integer out as a ULEB128/SLEB128 byte sequence
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    leb128_encoder_if slave: operand handshake in, byte handshake out
module leb128_encoder #(
    parameter int WIDTH = 64
) (
    input  logic clk,
    input  logic reset,
    leb128_encoder_if.slave bus
);
    localparam int MAX_BYTES = (WIDTH + 6) / 7;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             sgn_q, sgn_d;
    logic [3:0]       idx_q, idx_d;
    logic [WIDTH-1:0] sra, srl;
    logic             last, emit;

    assign sra  = $signed(val_q) >>> 7;
    assign srl  = val_q >> 7;
    // Signed sequences end once the remainder is pure sign extension of payload bit 6;
    // the index cap guarantees termination at MAX_BYTES regardless.
    assign last = (idx_q == 4'(MAX_BYTES - 1)) | (sgn_q ? (sra == {WIDTH{val_q[6]}}) : (srl == '0));
    assign emit = state_q == EMIT;

    // Outputs are masked outside EMIT so reset and idle both present all-zero bytes.
    assign bus.in_ready  = (state_q == IDLE) & ~reset;
    assign bus.out_valid = emit;
    assign bus.out_last  = emit & last;
    assign bus.out_byte  = emit ? {~last, val_q[6:0]} : 8'h00;
    assign bus.out_index = idx_q;

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        if (state_q == IDLE) begin
            if (bus.in_valid) begin
                state_d = EMIT;
                val_d   = bus.in_value;
                sgn_d   = bus.in_signed;
                idx_d   = 4'd0;
            end
        end else if (bus.out_ready) begin
            state_d = last ? IDLE : EMIT;
            val_d   = last ? val_q : (sgn_q ? sra : srl);
            idx_d   = last ? idx_q : idx_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            val_q   <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_leb128_encoder.sv
// tb_leb128_encoder: directed-vector bench for 64- and 32-bit LEB128 encoder instances
module tb_leb128_encoder;
    typedef byte unsigned bq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    bq_t  q64, q32;
    int   i64 = 0;
    int   i32 = 0;

    always #5 clk = ~clk;

    leb128_encoder_if #(.WIDTH(64)) b64 ();
    leb128_encoder_if #(.WIDTH(32)) b32 ();

    leb128_encoder #(.WIDTH(64)) u64 (.clk(clk), .reset(reset), .bus(b64.slave));
    leb128_encoder #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));

    // Reference LEB128 encoding: emit 7 bits at a time until the remainder carries no more information.
    function automatic bq_t enc(logic [63:0] v, bit s, int w);
        bq_t q;
        logic [63:0] x;
        byte unsigned b;
        bit done;
        x = (w == 32) ? (s ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]}) : v;
        done = 1'b0;
        while (!done) begin
            b = byte'(x[6:0]);
            x = s ? 64'($signed(x) >>> 7) : x >> 7;
            done = s ? ((x == 64'd0 && !b[6]) || (x == '1 && b[6])) : (x == 64'd0);
            if (!done) b = b | 8'h80;
            q.push_back(b);
        end
        return q;
    endfunction

    function automatic logic [79:0] pk(bq_t q);
        logic [79:0] r;
        r = '0;
        foreach (q[i]) r = {r[71:0], q[i]};
        return r;
    endfunction

    task automatic check(string nm, logic [79:0] act, logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pin(string nm, bq_t q, int n, logic [79:0] exp);
        check({nm, "_len"}, 80'(q.size()), 80'(n));
        check(nm, pk(q), exp);
    endtask

    // Per-cycle scoreboard for the 64-bit instance.
    always @(negedge clk) begin
        if (reset) begin
            q64.delete();
            i64 = 0;
        end else begin
            check("in_ready64", 80'(b64.in_ready), 80'(q64.size() == 0));
            check("out_valid64", 80'(b64.out_valid), 80'(q64.size() != 0));
            if (b64.out_valid && q64.size() != 0) begin
                check("byte64", 80'(b64.out_byte), 80'(q64[0]));
                check("last64", 80'(b64.out_last), 80'(q64.size() == 1));
                check("index64", 80'(b64.out_index), 80'(i64));
                if (b64.out_ready) begin
                    void'(q64.pop_front());
                    i64 = (q64.size() == 0) ? 0 : i64 + 1;
                end
            end
            if (b64.in_valid && b64.in_ready) q64 = enc(b64.in_value, b64.in_signed, 64);
        end
    end

    // Per-cycle scoreboard for the 32-bit instance.
    always @(negedge clk) begin
        if (reset) begin
            q32.delete();
            i32 = 0;
        end else begin
            check("in_ready32", 80'(b32.in_ready), 80'(q32.size() == 0));
            check("out_valid32", 80'(b32.out_valid), 80'(q32.size() != 0));
            if (b32.out_valid && q32.size() != 0) begin
                check("byte32", 80'(b32.out_byte), 80'(q32[0]));
                check("last32", 80'(b32.out_last), 80'(q32.size() == 1));
                check("index32", 80'(b32.out_index), 80'(i32));
                if (b32.out_ready) begin
                    void'(q32.pop_front());
                    i32 = (q32.size() == 0) ? 0 : i32 + 1;
                end
            end
            if (b32.in_valid && b32.in_ready) q32 = enc({32'b0, b32.in_value}, b32.in_signed, 32);
        end
    end

    task automatic send(bit w32, logic [63:0] v, bit s);
        bit got;
        @(posedge clk) #1;
        if (w32) begin
            b32.in_value = v[31:0];
            b32.in_signed = s;
            b32.in_valid = 1'b1;
        end else begin
            b64.in_value = v;
            b64.in_signed = s;
            b64.in_valid = 1'b1;
        end
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = w32 ? b32.in_ready : b64.in_ready;
        end
        check("accept_timeout", 80'(got), 80'(1));
        @(posedge clk) #1;
        b32.in_valid = 1'b0;
        b64.in_valid = 1'b0;
    endtask

    task automatic wait_done(bit w32);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            done = w32 ? (b32.in_ready && q32.size() == 0) : (b64.in_ready && q64.size() == 0);
        end
        check("done_timeout", 80'(done), 80'(1));
    endtask

    initial begin
        b64.in_valid = 1'b0; b64.in_value = '0; b64.in_signed = 1'b0; b64.out_ready = 1'b1;
        b32.in_valid = 1'b0; b32.in_value = '0; b32.in_signed = 1'b0; b32.out_ready = 1'b1;

        pin("pin_624485", enc(64'd624485, 1'b0, 64), 3, 80'hE58E26);
        pin("pin_m123456", enc(64'hFFFF_FFFF_FFFE_1DC0, 1'b1, 64), 3, 80'hC0BB78);
        pin("pin_m1", enc('1, 1'b1, 64), 1, 80'h7F);
        pin("pin_s64", enc(64'd64, 1'b1, 64), 2, 80'hC000);
        pin("pin_s63", enc(64'd63, 1'b1, 64), 1, 80'h3F);
        pin("pin_zero", enc(64'd0, 1'b1, 64), 1, 80'h00);
        pin("pin_umax", enc('1, 1'b0, 64), 10, 80'hFFFF_FFFF_FFFF_FFFF_FF01);
        pin("pin_smin", enc(64'h8000_0000_0000_0000, 1'b1, 64), 10, 80'h8080_8080_8080_8080_807F);
        pin("pin_umax32", enc(64'hFFFF_FFFF, 1'b0, 32), 5, 80'hFF_FFFF_FF0F);
        pin("pin_smin32", enc(64'h8000_0000, 1'b1, 32), 5, 80'h80_8080_8078);

        repeat (2) @(negedge clk);
        check("rst_in_ready", 80'(b64.in_ready), 80'(0));
        check("rst_out_valid", 80'(b64.out_valid), 80'(0));
        check("rst_out_byte", 80'(b64.out_byte), 80'(0));
        check("rst_out_last", 80'(b64.out_last), 80'(0));
        check("rst_out_index", 80'(b64.out_index), 80'(0));
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 80'(b64.in_ready), 80'(1));

        send(1'b0, 64'd624485, 1'b0); wait_done(1'b0);
        send(1'b0, 64'hFFFF_FFFF_FFFE_1DC0, 1'b1); wait_done(1'b0);
        send(1'b0, '1, 1'b1); wait_done(1'b0);
        send(1'b0, 64'd64, 1'b1); wait_done(1'b0);
        send(1'b0, 64'd63, 1'b1); wait_done(1'b0);
        send(1'b0, '1, 1'b0); wait_done(1'b0);
        send(1'b0, 64'h8000_0000_0000_0000, 1'b1); wait_done(1'b0);
        send(1'b0, 64'd0, 1'b0); wait_done(1'b0);

        // Backpressure on byte 1 of 624485.
        b64.out_ready = 1'b0;
        send(1'b0, 64'd624485, 1'b0);
        for (int k = 0; k < 20 && !b64.out_valid; k++) @(negedge clk);
        @(posedge clk) #1 b64.out_ready = 1'b1;
        @(posedge clk) #1 b64.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_byte", 80'(b64.out_byte), 80'h8E);
            check("bp_valid", 80'(b64.out_valid), 80'(1));
            check("bp_in_ready", 80'(b64.in_ready), 80'(0));
        end
        @(posedge clk) #1 b64.out_ready = 1'b1;
        wait_done(1'b0);

        // Asynchronous reset mid-sequence.
        send(1'b0, 64'd624485, 1'b0);
        for (int k = 0; k < 20 && b64.out_index != 4'd1; k++) @(negedge clk);
        check("mid_index", 80'(b64.out_index), 80'(1));
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", 80'(b64.out_valid), 80'(0));
        check("arst_in_ready", 80'(b64.in_ready), 80'(0));
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("arst_rel_in_ready", 80'(b64.in_ready), 80'(1));
        send(1'b0, 64'd0, 1'b0);
        check("zero_byte", 80'(b64.out_byte), 80'h00);
        check("zero_last", 80'(b64.out_last), 80'(1));
        check("zero_valid", 80'(b64.out_valid), 80'(1));
        wait_done(1'b0);

        send(1'b1, 64'hFFFF_FFFF, 1'b0); wait_done(1'b1);
        send(1'b1, 64'h8000_0000, 1'b1); wait_done(1'b1);
        send(1'b1, 64'hFFFF_FFFF, 1'b1); wait_done(1'b1);
        send(1'b1, 64'd624485, 1'b0); wait_done(1'b1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
